mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates a single-port synchronous data memory between the CPU MEM stage and the UART loader/debug requester. It sequences every memory access, returns read data with a one-cycle acknowledge, and drives `cpu_stall` so the pipeline registers ahead of the MEM stage hold while the CPU access is pending. The CPU has fixed priority, and an anti-starvation counter guarantees the UART a slot.

## Interface
- `AW`, default 16: address width.
- `DW`, default 16: data width.
- `UART_MAX_WAIT`, default 4: number of lost arbitrations after which the UART wins; legal range 1..255.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU access request; held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  AW  CPU address.
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DW  read data; valid only while `cpu_ack`=1.
- `cpu_stall`  out  1  `cpu_req & ~cpu_ack`; combinational.
- `uart_req`, `uart_we`, `uart_addr`, `uart_wdata`, `uart_ack`, `uart_rdata`: same definitions as the CPU port, for the UART requester.
- `mem_en`  out  1  memory access strobe; registered.
- `mem_we`  out  1  memory write enable; registered.
- `mem_addr`  out  AW  memory address; registered.
- `mem_wdata`  out  DW  memory write data; registered.
- `mem_rdata`  in  DW  memory read data, valid the cycle after `mem_en` is sampled.

## Operation
- FSM states and transitions:
  - IDLE: arbitrates when any request is present, then goes to ISSUE.
  - ISSUE: goes to RESP unconditionally.
  - RESP: goes to IDLE unconditionally.
- Arbitration, evaluated only in IDLE:
  - If `uart_req` and `wait_cnt == UART_MAX_WAIT`, the UART wins.
  - Otherwise, if `cpu_req`, the CPU wins.
  - Otherwise, if `uart_req`, the UART wins.
- Grant action, on the edge leaving IDLE:
  - Latch the owner.
  - Register `mem_en`=1, `mem_we`, `mem_addr` and `mem_wdata` from the winning port.
- ISSUE→RESP edge: clear `mem_en` and `mem_we`. `mem_addr` and `mem_wdata` keep their values.
- RESP: assert the owner's ack (registered, set on the ISSUE→RESP edge); its `*_rdata` = `mem_rdata` (pass-through). The other port's ack stays 0.
- `wait_cnt` (8 bit) updates only on IDLE grant edges:
  - CPU wins while `uart_req`=1: increment, saturating at `UART_MAX_WAIT`.
  - UART wins: clear to 0.
  - Otherwise: hold.
- Requesters drop `req` after sampling ack. A `req` still high in the following IDLE cycle is a new request.
- Writes also receive an ack in RESP; `*_rdata` is don't-care.

## Timing
- Reset values: state IDLE, `wait_cnt` 0, `mem_en` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, both acks 0. `*_rdata` follow `mem_rdata`.
- Latency, with the request seen in IDLE in cycle N:
  - `mem_en`=1 in N+1.
  - Ack in N+2.
  - Earliest next grant edge ends N+3.
  - Throughput is 1 access per 3 cycles.
- `cpu_stall`=1 in cycles N..N+1 and 0 in N+2. This holds when the request is not blocked; if the UART owns the port, the stall extends by the UART's remaining cycles.
- Requests arriving during ISSUE or RESP wait for the next IDLE cycle; they are never dropped.
- Simultaneous requests with `wait_cnt < UART_MAX_WAIT`: CPU first, UART serviced in the next IDLE if CPU `req` is deasserted.
- `req` deasserted before ack (protocol violation): the access still completes and acks. No cancel is supported.
- Reset asserted mid-access: immediately return to IDLE, `mem_en` 0, no ack emitted, `wait_cnt` 0.

## Test plan
1. CPU read alone: memory preloaded `0x0010`=`0xBEEF`; `cpu_req`=1, `we`=0, `addr`=`0x0010` in IDLE → `mem_en`=1 next cycle with `mem_addr`=`0x0010`; `cpu_ack`=1 two cycles after the request with `cpu_rdata`=`0xBEEF`; `cpu_stall`=1 for exactly 2 cycles.
2. UART write then CPU read-back: UART writes `0x1234` to `0x00A0` → `uart_ack` 2 cycles after the request, `mem_we`=1 for one cycle; CPU then reads `0x00A0` → `0x1234`.
3. Simultaneous requests: both `req` asserted in the same IDLE cycle → CPU acks first; UART `mem_en` follows in the IDLE after the CPU's RESP; `wait_cnt` increments to 1, then clears.
4. Starvation guard (`UART_MAX_WAIT`=4): CPU re-requests every IDLE cycle while `uart_req` is held high → CPU wins 4 arbitrations; the 5th grant goes to the UART; `cpu_stall` stays high for those 3 cycles.
5. Reset in ISSUE: assert `reset`=0 while `mem_en`=1 → `mem_en` drops asynchronously; no ack on either port; after release, a new CPU read completes with normal 2-cycle latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/UART arbiter for a single-port synchronous data memory
// Fixed CPU priority, a 3-cycle access sequence, and a lost-arbitration counter that guarantees the UART a slot.
module mem_port_arbiter #(
  parameter int AW            = 16,
  parameter int DW            = 16,
  parameter int UART_MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          uart_req,
  input  logic          uart_we,
  input  logic [AW-1:0] uart_addr,
  input  logic [DW-1:0] uart_wdata,
  output logic          uart_ack,
  output logic [DW-1:0] uart_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [7:0] MAX_WAIT = 8'(UART_MAX_WAIT);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          uart_ack_q, uart_ack_d;
  logic          uart_wins;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wait_cnt_d  = wait_cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    uart_ack_d  = 1'b0;
    // owner 1 means the UART holds the port
    uart_wins   = uart_req && ((wait_cnt_q == MAX_WAIT) || !cpu_req);
    case (state_q)
      IDLE: begin
        if (cpu_req || uart_req) begin
          state_d     = ISSUE;
          owner_d     = uart_wins;
          mem_en_d    = 1'b1;
          mem_we_d    = uart_wins ? uart_we    : cpu_we;
          mem_addr_d  = uart_wins ? uart_addr  : cpu_addr;
          mem_wdata_d = uart_wins ? uart_wdata : cpu_wdata;
          if (uart_wins)
            wait_cnt_d = '0;
          else if (uart_req && (wait_cnt_q < MAX_WAIT))
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ISSUE: begin
        state_d    = RESP;
        cpu_ack_d  = !owner_q;
        uart_ack_d = owner_q;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      wait_cnt_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      uart_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      uart_ack_q  <= uart_ack_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign uart_ack   = uart_ack_q;
  assign cpu_rdata  = mem_rdata;
  assign uart_rdata = mem_rdata;
  assign cpu_stall  = cpu_req & ~cpu_ack_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter
// The reference predicts every output from the grant cycle number and a shadow memory.
module tb_mem_port_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int MAXW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          uart_req = 1'b0, uart_we = 1'b0;
  logic [AW-1:0] uart_addr = '0;
  logic [DW-1:0] uart_wdata = '0;
  logic          cpu_ack, cpu_stall, uart_ack;
  logic [DW-1:0] cpu_rdata, uart_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .UART_MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_ack(uart_ack), .uart_rdata(uart_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 'h10) return 16'hBEEF;
    return 16'(a * 'h3C5 + 'h1111);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous memory the arbiter drives: read data appears the cycle after mem_en.
  logic [DW-1:0] env_mem [256];
  initial begin
    for (int i = 0; i < 256; i++) env_mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) env_mem[mem_addr[7:0]] = mem_wdata;
        else        mem_rdata <= env_mem[mem_addr[7:0]];
      end
    end
  end

  // Reference: one access in flight, known by its grant cycle; ISSUE is grant+1, ack is grant+2.
  logic [DW-1:0] ref_mem [256];
  int            cyc = 0, g_cyc = 0, wcnt = 0;
  bit            g_valid = 0, g_uart = 0, g_we = 0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_wdata = '0, g_rdata = '0;
  bit            e_en, e_cack, e_uack;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        g_valid = 0; wcnt = 0; last_addr = '0; last_wdata = '0;
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_uart_ack", uart_ack, 0);
        check("rst_cpu_stall", cpu_stall, cpu_req);
      end else begin
        e_en   = g_valid && (cyc == g_cyc + 1);
        e_cack = g_valid && (cyc == g_cyc + 2) && !g_uart;
        e_uack = g_valid && (cyc == g_cyc + 2) && g_uart;
        check("m_mem_en", mem_en, e_en);
        check("m_mem_we", mem_we, e_en && g_we);
        check("m_mem_addr", mem_addr, last_addr);
        check("m_mem_wdata", mem_wdata, last_wdata);
        check("m_cpu_ack", cpu_ack, e_cack);
        check("m_uart_ack", uart_ack, e_uack);
        check("m_cpu_stall", cpu_stall, cpu_req && !e_cack);
        if (e_cack && !g_we) check("m_cpu_rdata", cpu_rdata, g_rdata);
        if (e_uack && !g_we) check("m_uart_rdata", uart_rdata, g_rdata);
        if ((!g_valid || cyc >= g_cyc + 3) && (cpu_req || uart_req)) begin
          g_uart = uart_req && (wcnt == MAXW || !cpu_req);
          if (g_uart) wcnt = 0;
          else if (uart_req && wcnt < MAXW) wcnt++;
          g_valid    = 1;
          g_cyc      = cyc;
          g_we       = g_uart ? uart_we : cpu_we;
          last_addr  = g_uart ? uart_addr : cpu_addr;
          last_wdata = g_uart ? uart_wdata : cpu_wdata;
          if (g_we) ref_mem[last_addr[7:0]] = last_wdata;
          else      g_rdata = ref_mem[last_addr[7:0]];
        end
      end
    end
  end

  task automatic access(input bit uart, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
    @(posedge clk); #1;
    if (uart) begin uart_req = 1; uart_we = we; uart_addr = addr; uart_wdata = wd; end
    else      begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
    @(negedge clk);
    check("acc_req_mem_en", mem_en, 0);
    check("acc_req_stall", cpu_stall, !uart);
    @(negedge clk);
    check("acc_issue_mem_en", mem_en, 1);
    check("acc_issue_mem_we", mem_we, we);
    check("acc_issue_addr", mem_addr, addr);
    if (we) check("acc_issue_wdata", mem_wdata, wd);
    check("acc_issue_stall", cpu_stall, !uart);
    @(negedge clk);
    check("acc_resp_cpu_ack", cpu_ack, !uart);
    check("acc_resp_uart_ack", uart_ack, uart);
    check("acc_resp_mem_en", mem_en, 0);
    check("acc_resp_stall", cpu_stall, 0);
    if (!we) check("acc_resp_rdata", uart ? uart_rdata : cpu_rdata, exp_rd);
    @(posedge clk); #1;
    cpu_req = 0; uart_req = 0;
  endtask

  task automatic random_phase(input int cycles, input int p_cpu, input int p_uart);
    bit   cpend = 0, upend = 0;
    logic ca, ua;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      ca = cpu_ack; ua = uart_ack;
      @(posedge clk); #1;
      if (ca) cpend = 0;
      if (ua) upend = 0;
      // occasional early drop: the access must still complete
      if (cpend && $urandom_range(0, 99) == 0) cpend = 0;
      if (!cpend && $urandom_range(0, 99) < p_cpu) begin
        cpend = 1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 16'($urandom_range(0, 31)); cpu_wdata = 16'($urandom);
      end
      if (!upend && $urandom_range(0, 99) < p_uart) begin
        upend = 1; uart_we = 1'($urandom_range(0, 1));
        uart_addr = 16'($urandom_range(0, 31)); uart_wdata = 16'($urandom);
      end
      cpu_req = cpend; uart_req = upend;
    end
    @(posedge clk); #1;
    cpu_req = 0; uart_req = 0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int       ng;
    logic [4:0] owners;
    repeat (3) @(negedge clk);
    #2 reset = 1;

    access(0, 0, 16'h0010, 16'h0000, 16'hBEEF);
    access(1, 1, 16'h00A0, 16'h1234, 16'h0000);
    access(0, 0, 16'h00A0, 16'h0000, 16'h1234);

    // simultaneous requests: CPU first, UART in the following IDLE
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
    uart_req = 1; uart_we = 0; uart_addr = 16'h0050;
    @(negedge clk);
    @(negedge clk);
    check("sim_first_addr", mem_addr, 16'h0040);
    @(negedge clk);
    check("sim_cpu_ack", cpu_ack, 1);
    check("sim_uart_ack0", uart_ack, 0);
    check("sim_cpu_rdata", cpu_rdata, init_val('h40));
    @(posedge clk); #1;
    cpu_req = 0;
    @(negedge clk);
    check("sim_idle_en", mem_en, 0);
    @(negedge clk);
    check("sim_uart_en", mem_en, 1);
    check("sim_uart_addr", mem_addr, 16'h0050);
    @(negedge clk);
    check("sim_uart_ack", uart_ack, 1);
    check("sim_uart_rdata", uart_rdata, init_val('h50));
    @(posedge clk); #1;
    uart_req = 0;

    // starvation guard: four CPU wins, then the UART
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
    uart_req = 1; uart_we = 0; uart_addr = 16'h00C0;
    ng = 0; owners = '0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (mem_en) begin
        if (ng < 5) owners[ng] = (mem_addr == 16'h00C0);
        ng++;
      end
      if (i == 11) check("starve_4th_cpu_ack", cpu_ack, 1);
      if (i >= 12) check("starve_stall", cpu_stall, 1);
      if (i == 14) check("starve_uart_ack", uart_ack, 1);
    end
    @(posedge clk); #1;
    cpu_req = 0; uart_req = 0;
    check("starve_grants", ng, 5);
    check("starve_order", owners, 5'b10000);

    // reset while the access is in ISSUE
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0030;
    @(negedge clk);
    @(negedge clk);
    check("rst5_issue_en", mem_en, 1);
    #2 reset = 0;
    #1 check("rst5_async_en", mem_en, 0);
    @(posedge clk); #1;
    cpu_req = 0;
    @(negedge clk);
    check("rst5_cpu_ack", cpu_ack, 0);
    check("rst5_uart_ack", uart_ack, 0);
    #2 reset = 1;
    @(negedge clk);
    check("rst5_after_cpu_ack", cpu_ack, 0);
    check("rst5_after_en", mem_en, 0);
    access(0, 0, 16'h0030, 16'h0000, init_val('h30));

    random_phase(1500, 60, 30);
    random_phase(1500, 95, 90);
    random_phase(1000, 20, 20);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
